// File: rtl/instr_controller.sv
// instr_controller: instruction-sequencing FSM driving the datapath controls.
// Latches a 16-bit instruction on start, walks a fixed per-instruction state
// sequence and presents Moore-style control outputs plus the sign-extended
// immediate for the datapath input.
module instr_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] in,
  output logic        w,
  output logic        illegal,
  output logic [15:0] sximm8,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
);

  typedef enum logic [2:0] {
    WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;

  logic [2:0]  opcode;
  logic [1:0]  op;
  logic        is_mov_imm;
  logic        is_mov_reg;
  logic        is_alu;
  logic        is_cmp;
  logic        is_mvn;
  logic        single_operand;

  assign opcode         = ir[15:13];
  assign op             = ir[12:11];
  assign is_mov_imm     = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg     = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu         = (opcode == 3'b101);
  assign is_cmp         = is_alu && (op == 2'b01);
  assign is_mvn         = is_alu && (op == 2'b11);
  assign single_operand = is_mov_reg || is_mvn;

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  // State register; reset abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (reset) state <= WAIT;
    else       state <= next_state;
  end

  // Instruction register, loaded only when starting from WAIT
  always_ff @(posedge clk) begin
    if (reset)                    ir <= 16'h0000;
    else if (state == WAIT && s)  ir <= in;
  end

  // Next-state logic following the per-instruction sequence
  always_comb begin
    next_state = WAIT;
    unique case (state)
      WAIT:    next_state = s ? DECODE : WAIT;
      DECODE: begin
        if (is_mov_imm)          next_state = WR_IMM;
        else if (single_operand) next_state = GET_B;
        else if (is_alu)         next_state = GET_A;
        else                     next_state = WAIT;
      end
      GET_A:   next_state = GET_B;
      GET_B:   next_state = ALU;
      ALU:     next_state = is_cmp ? WAIT : WR_REG;
      WR_REG:  next_state = WAIT;
      WR_IMM:  next_state = WAIT;
      default: next_state = WAIT;
    endcase
  end

  // Moore control outputs decoded from the current state and latched IR
  always_comb begin
    w        = 1'b0;
    illegal  = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    ALUop    = 2'b00;
    shift    = (is_alu || is_mov_reg) ? ir[4:3] : 2'b00;
    unique case (state)
      WAIT:   w = 1'b1;
      DECODE: illegal = !(is_mov_imm || is_mov_reg || is_alu);
      GET_A: begin
        readnum = ir[10:8];
        loada   = 1'b1;
      end
      GET_B: begin
        readnum = ir[2:0];
        loadb   = 1'b1;
      end
      ALU: begin
        asel  = single_operand;
        ALUop = is_mov_reg ? 2'b00 : op;
        loads = is_cmp;
        loadc = !is_cmp;
      end
      WR_REG: begin
        write    = 1'b1;
        writenum = ir[7:5];
      end
      WR_IMM: begin
        write    = 1'b1;
        vsel     = 1'b1;
        writenum = ir[10:8];
      end
      default: w = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_instr_controller.sv
// tb_instr_controller: scoreboard bench for instr_controller. Stimulus pushes
// the expected per-cycle control vectors of each issued instruction into a
// queue; a monitor pops and compares on every busy cycle and checks the idle
// vector on every WAIT cycle.
module tb_instr_controller;

  logic        clk;
  logic        reset;
  logic        s;
  logic [15:0] in;
  logic        w;
  logic        illegal;
  logic [15:0] sximm8;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;

  instr_controller dut (
    .clk(clk), .reset(reset), .s(s), .in(in),
    .w(w), .illegal(illegal), .sximm8(sximm8),
    .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .shift(shift), .ALUop(ALUop)
  );

  typedef struct packed {
    logic        w;
    logic        illegal;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  shift;
    logic [1:0]  alu;
    logic [15:0] sximm8;
  } ctl_t;

  typedef struct {
    ctl_t        c;
    bit          first;
    logic [15:0] ir;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] lastIr;
  bit          monOn;
  int          total;
  int          bad;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Controls that follow the latched instruction in every state
  function automatic ctl_t baseCtl(input logic [15:0] ir);
    ctl_t c;
    c = '0;
    if (ir[15:13] == 3'b101 || ir[15:11] == 5'b11000) c.shift = ir[4:3];
    c.sximm8 = {{8{ir[7]}}, ir[7:0]};
    return c;
  endfunction

  task automatic pushOne(input ctl_t c, input bit first, input logic [15:0] ir);
    exp_t e;
    e.c     = c;
    e.first = first;
    e.ir    = ir;
    expQ.push_back(e);
  endtask

  // Reference model: expand one instruction into its busy-cycle vectors
  task automatic pushExpected(input logic [15:0] ir);
    logic [2:0] opc;
    logic [1:0] op;
    bit movImm, movReg, arith, cmp, oneOp;
    ctl_t c;
    opc    = ir[15:13];
    op     = ir[12:11];
    movImm = (opc == 3'd6) && (op == 2'd2);
    movReg = (opc == 3'd6) && (op == 2'd0);
    arith  = (opc == 3'd5);
    cmp    = arith && (op == 2'd1);
    oneOp  = movReg || (arith && op == 2'd3);
    c = baseCtl(ir);
    c.illegal = !(movImm || movReg || arith);
    pushOne(c, 1'b1, ir);
    if (movImm) begin
      c = baseCtl(ir);
      c.write = 1'b1; c.vsel = 1'b1; c.writenum = ir[10:8];
      pushOne(c, 1'b0, ir);
    end else if (movReg || arith) begin
      if (!oneOp) begin
        c = baseCtl(ir);
        c.readnum = ir[10:8]; c.loada = 1'b1;
        pushOne(c, 1'b0, ir);
      end
      c = baseCtl(ir);
      c.readnum = ir[2:0]; c.loadb = 1'b1;
      pushOne(c, 1'b0, ir);
      c = baseCtl(ir);
      c.asel  = oneOp;
      c.alu   = movReg ? 2'd0 : op;
      c.loads = cmp;
      c.loadc = !cmp;
      pushOne(c, 1'b0, ir);
      if (!cmp) begin
        c = baseCtl(ir);
        c.write = 1'b1; c.writenum = ir[7:5];
        pushOne(c, 1'b0, ir);
      end
    end
  endtask

  task automatic checkOutput(input string name, input ctl_t act, input ctl_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare every sampled cycle against the scoreboard
  always @(negedge clk) begin
    ctl_t act;
    ctl_t exp;
    exp_t e;
    if (monOn) begin
      act = '{w: w, illegal: illegal, write: write, vsel: vsel, loada: loada,
              loadb: loadb, loadc: loadc, loads: loads, asel: asel, bsel: bsel,
              readnum: readnum, writenum: writenum, shift: shift, alu: ALUop,
              sximm8: sximm8};
      if (w !== 1'b1) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_busy t=%0t got=%h want=idle", $time, act);
        end else begin
          e = expQ.pop_front();
          lastIr = e.ir;
          checkOutput("busy_cycle", act, e.c);
        end
      end else begin
        exp = baseCtl(lastIr);
        exp.w = 1'b1;
        checkOutput("idle_cycle", act, exp);
        if (expQ.size() > 0) begin
          total++;
          if (!expQ[0].first) begin
            bad++;
            $display("[TB] FAIL early_wait t=%0t got=w1 want=busy remaining=%0d",
                     $time, expQ.size());
          end
        end
      end
    end
  end

  // Start an instruction from WAIT (called one step after a rising edge)
  task automatic applyStimulus(input logic [15:0] ir);
    s  = 1'b1;
    in = ir;
    pushExpected(ir);
    @(posedge clk); #1;
    s  = 1'b0;
  endtask

  // Run busy cycles with random s/in noise until WAIT, bounded
  task automatic waitIdle();
    int n;
    n = 0;
    while (w !== 1'b1 && n < 12) begin
      s  = 1'($urandom_range(0, 1));
      in = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    s = 1'b0;
    if (w !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_timeout t=%0t got=w%b want=w1", $time, w);
    end
  endtask

  task automatic runInstr(input logic [15:0] ir, input int gap);
    for (int i = 0; i < gap; i++) begin
      s = 1'b0;
      @(posedge clk); #1;
    end
    applyStimulus(ir);
    waitIdle();
  endtask

  function automatic logic [15:0] randInstr();
    logic [15:0] r;
    int sel;
    r   = 16'($urandom);
    sel = $urandom_range(0, 9);
    if (sel < 4)      r[15:13] = 3'b101;
    else if (sel < 8) begin
      r[15:13] = 3'b110;
      r[11]    = 1'b0;
    end
    return r;
  endfunction

  // Directed sequence, mid-instruction reset, then randomized traffic
  initial begin
    total  = 0;
    bad    = 0;
    monOn  = 1'b0;
    lastIr = 16'h0000;
    reset  = 1'b1;
    s      = 1'b1;
    in     = 16'hFFFF;
    @(posedge clk); #1;
    monOn = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    s     = 1'b0;

    runInstr(16'hD007, 1);
    runInstr(16'hD3FB, 0);
    runInstr(16'hD102, 0);
    runInstr(16'hA148, 0);
    runInstr(16'hA801, 2);
    runInstr(16'hE000, 0);
    runInstr(16'hC01A, 0);
    runInstr(16'hB86B, 1);
    runInstr(16'hB2F2, 0);

    // Reset asserted during GET_B of an ADD, with s held high
    applyStimulus(16'hA148);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    s     = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    s     = 1'b0;
    expQ.delete();
    lastIr = 16'h0000;
    @(posedge clk); #1;

    for (int k = 0; k < 300; k++) begin
      runInstr(randInstr(), $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0);
    end

    @(posedge clk); #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got=%0d want=0", expQ.size());
    end
    monOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
